// File: rtl/instr_issuer_if.sv
// Host-side push handshake of the instruction issuer: the host offers a word,
// the issuer reports whether it can take one this cycle.
interface instr_issuer_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/instr_issuer.sv
// Instruction issue unit: buffers host words in a circular FIFO and feeds the
// ALU core one word (or NOP) per cycle. Optional macro: ISSUER_DROP_ILLEGAL_EN.
module instr_issuer #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] NOP_WORD = 16'h5000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_issuer_if.slave              host,
    input  logic                       pause,
    input  logic                       flush,
    output logic [15:0]                instruction,
    output logic                       issue_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                issued_cnt,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {EMPTY, RUN, PAUSED} state_t;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    state_t        state_q;
    logic [15:0]   instruction_q;
    logic          issue_valid_q;
    logic [15:0]   issued_q;

    logic accept, push, pop;

    // Ready ignores a same-cycle pop, so a full FIFO refuses even while draining.
    assign host.in_ready = (count_q != FULL) && !flush;
    assign accept        = host.in_valid && host.in_ready;
    assign pop           = !pause && !flush && (count_q != '0);

`ifdef ISSUER_DROP_ILLEGAL_EN
    logic       illegal;
    logic [7:0] drop_q;

    assign illegal  = host.in_data[15:12] inside {4'h5, 4'h6, 4'h7};
    assign push     = accept && !illegal;
    assign drop_cnt = drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_q <= '0;
        else if (accept && illegal && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end
`else
    assign push     = accept;
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= host.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Issue FSM with registered outputs; the head word is read before any pointer moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            instruction_q <= NOP_WORD;
            issue_valid_q <= 1'b0;
            issued_q      <= '0;
        end else begin
            if (pop) begin
                instruction_q <= mem_q[rptr_q];
                issue_valid_q <= 1'b1;
                issued_q      <= issued_q + 16'd1;
            end else begin
                instruction_q <= NOP_WORD;
                issue_valid_q <= 1'b0;
            end
            case (state_q)
                PAUSED: begin
                    if (flush)                state_q <= EMPTY;
                    else if (pause)           state_q <= PAUSED;
                    else if (count_q == '0)   state_q <= EMPTY;
                    else                      state_q <= RUN;
                end
                EMPTY, RUN: begin
                    if (flush)                state_q <= EMPTY;
                    else if (pause)           state_q <= PAUSED;
                    else if (count_q == '0)   state_q <= EMPTY;
                    else                      state_q <= RUN;
                end
                default:                      state_q <= EMPTY;
            endcase
        end
    end

    assign instruction = instruction_q;
    assign issue_valid = issue_valid_q;
    assign fifo_count  = count_q;
    assign issued_cnt  = issued_q;
endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: directed vector table, hand sequences and random
// traffic, all checked against a queue-based model of the issue rules.
module tb_instr_issuer;
    localparam int          DEPTH = 8;
    localparam logic [15:0] NOP   = 16'h5000;
`ifdef ISSUER_DROP_ILLEGAL_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, pause, flush;
    logic [15:0] instruction, issued_cnt;
    logic        issue_valid;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_cnt;

    instr_issuer_if bus();

    instr_issuer #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .host(bus), .pause(pause), .flush(flush),
        .instruction(instruction), .issue_valid(issue_valid),
        .fifo_count(fifo_count), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mq[$];
    logic [15:0] m_instr  = NOP;
    logic        m_iv     = 1'b0;
    logic [15:0] m_issued = '0;
    logic [7:0]  m_drop   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus, with the model advanced across the edge.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic p, input logic f);
        bit rdy;
        rst_n = r; bus.in_valid = v; bus.in_data = d; pause = p; flush = f;
        rdy = (mq.size() != DEPTH) && !f;
        @(negedge clk);
        if (r) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        @(posedge clk);
        if (!r) begin
            mq.delete(); m_instr = NOP; m_iv = 1'b0; m_issued = '0; m_drop = '0;
        end else begin
            if (!p && !f && mq.size() > 0) begin
                m_instr = mq.pop_front(); m_iv = 1'b1; m_issued = m_issued + 16'd1;
            end else begin
                m_instr = NOP; m_iv = 1'b0;
            end
            if (v && rdy) begin
                if (DROP_EN && d[15:12] inside {4'h5, 4'h6, 4'h7}) begin
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end else mq.push_back(d);
            end
            if (f) mq.delete();
        end
        #1;
        chk("instruction", {16'd0, instruction}, {16'd0, m_instr});
        chk("issue_valid", {31'd0, issue_valid}, {31'd0, m_iv});
        chk("fifo_count",  {28'd0, fifo_count},  mq.size());
        chk("issued_cnt",  {16'd0, issued_cnt},  {16'd0, m_issued});
        chk("drop_cnt",    {24'd0, drop_cnt},    {24'd0, m_drop});
    endtask

    typedef struct {
        logic r, v, p, f;
        logic [15:0] d;
        logic [15:0] e_instr;
        logic        e_iv;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic v, logic [15:0] d, logic p, logic f,
                                logic [15:0] ei, logic eiv, logic [3:0] ec);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.p = p; t.f = f;
        t.e_instr = ei; t.e_iv = eiv; t.e_cnt = ec;
        tbl.push_back(t);
    endfunction

    initial begin
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; pause = 1'b0; flush = 1'b0;

        add(0, 1, 16'h9999, 0, 0, NOP, 0, 0);
        add(0, 0, 16'h0000, 0, 0, NOP, 0, 0);
        add(1, 1, 16'h0123, 0, 0, NOP, 0, 1);
        add(1, 0, 16'h0000, 0, 0, 16'h0123, 1, 0);
        add(1, 0, 16'h0000, 0, 0, NOP, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 1, 16'h8120 + 16'(i), 1, 0, NOP, 0, 4'(i + 1));
        add(1, 1, 16'h8128, 1, 0, NOP, 0, 8);
        for (int k = 0; k < 8; k++) add(1, 0, 16'h0000, 0, 0, 16'h8120 + 16'(k), 1, 4'(7 - k));
        add(1, 0, 16'h0000, 0, 0, NOP, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 16'h3000 + 16'(i), 1, 0, NOP, 0, 4'(i + 1));
        add(1, 1, 16'hA340, 0, 1, NOP, 0, 0);
        add(1, 0, 16'h0000, 0, 0, NOP, 0, 0);
        add(1, 0, 16'h0000, 0, 0, NOP, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].f);
            chk("tbl_instr", {16'd0, instruction}, {16'd0, tbl[i].e_instr});
            chk("tbl_iv",    {31'd0, issue_valid}, {31'd0, tbl[i].e_iv});
            chk("tbl_cnt",   {28'd0, fifo_count},  {28'd0, tbl[i].e_cnt});
        end
        chk("issued_after_tbl", {16'd0, issued_cnt}, 32'd9);

        // Fill, then drain with in_valid held high: one pop per cycle, pointers wrap.
        for (int i = 0; i < 8; i++) step(1, 1, 16'hC000 + 16'(i), 1, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 16'hD000 + 16'(i), 0, 0);
        chk("stream_occupancy", {28'd0, fifo_count}, 32'd7);
        for (int i = 0; i < 10; i++) step(1, 0, 16'h0000, 0, 0);

        // Reset mid-stream with five words buffered.
        for (int i = 0; i < 5; i++) step(1, 1, 16'hE000 + 16'(i), 1, 0);
        step(0, 0, 16'h0000, 0, 0);
        chk("rst_issued", {16'd0, issued_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0000, 0, 0);
            chk("rst_no_issue", {31'd0, issue_valid}, 32'd0);
        end

        // Illegal-opcode handling.
        step(1, 1, 16'h5111, 0, 0);
        step(1, 1, 16'h0456, 0, 0);
        step(1, 1, 16'h7000, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0000, 0, 0);
        chk("drop_total",   {24'd0, drop_cnt},   DROP_EN ? 32'd2 : 32'd0);
        chk("drop_issued",  {16'd0, issued_cnt}, DROP_EN ? 32'd1 : 32'd3);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, d,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
